// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter and its tag framing.
// Tag framing is compiled in only with UART_TX_ARB_TAG_EN.
package uart_pkg;

    localparam int        UART_DW  = 8;
    localparam logic [7:0] TAG_BASE = 8'hF0;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN
`ifdef UART_TX_ARB_TAG_EN
        ,
        TAG_LOAD,
        TAG_RUN
`endif
    } arb_state_t;

    function automatic logic [UART_DW-1:0] tag_byte(input logic [UART_DW-1:0] id);
        return TAG_BASE | id;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Producer-side request bus and send-side handshake of the UART transmit arbiter.
interface uart_tx_arbiter_if #(parameter int NREQ = 4);
    import uart_pkg::*;

    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]         req;
    logic [NREQ*UART_DW-1:0] req_data;
    logic [NREQ-1:0]         ack;
    logic [IDW-1:0]          grant_id;
    logic [UART_DW-1:0]      tx_data;
    logic                    tx_flag;
    logic                    tx_busy;
    logic                    idle;

    modport master (output req, req_data, tx_busy,
                    input  ack, grant_id, tx_data, tx_flag, idle);

    modport slave  (input  req, req_data, tx_busy,
                    output ack, grant_id, tx_data, tx_flag, idle);

endinterface

// File: rtl/send.sv
// Minimal 8N1 UART transmitter: start on flag low while idle, busy for the whole frame.
module send #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] data,
    input  logic       flag,
    output logic       busy,
    output logic       UART_TX
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [8:0]    shreg;
    logic [3:0]    bit_cnt;
    logic [CW-1:0] clk_cnt;

    // NOTE: all state here is updated with non-blocking assignments to avoid read/write races.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            busy    <= 1'b0;
            UART_TX <= 1'b1;
            shreg   <= '1;
            bit_cnt <= '0;
            clk_cnt <= '0;
        end else if (!busy) begin
            if (!flag) begin
                busy    <= 1'b1;
                UART_TX <= 1'b0;
                shreg   <= {1'b1, data};
                bit_cnt <= '0;
                clk_cnt <= '0;
            end
        end else if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
            clk_cnt <= '0;
            if (bit_cnt == 4'd9) begin
                busy <= 1'b0;
            end else begin
                UART_TX <= shreg[0];
                shreg   <= {1'b1, shreg[8:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end
        end else begin
            clk_cnt <= clk_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit above last, wrapping.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [IDW-1:0]  winner,
    output logic            found
);

    int idx;

    always_comb begin
        // NOTE: every output gets a default before the search so no latch is inferred.
        winner = last;
        found  = 1'b0;
        idx    = 0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = int'(last) + off;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[IDW'(idx)]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one send transmitter among NREQ byte producers.
// Define UART_TX_ARB_TAG_EN to prefix every byte with a TAG_BASE|grant_id frame.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ = 4
) (
    input logic               CLK,
    input logic               RESET_N,
    uart_tx_arbiter_if.slave  bus
);

    localparam int IDW = $clog2(NREQ);

    arb_state_t     state;
    logic [IDW-1:0] last;
    logic [IDW-1:0] pick_id;
    logic [IDW-1:0] winner;
    logic           pick_valid;
    logic           found;
`ifdef UART_TX_ARB_TAG_EN
    logic [UART_DW-1:0] hold;
`endif

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (bus.req),
        .last   (last),
        .winner (winner),
        .found  (found)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= IDLE;
            last         <= IDW'(NREQ - 1);
            pick_id      <= '0;
            pick_valid   <= 1'b0;
            bus.ack      <= '0;
            bus.grant_id <= '0;
            bus.tx_data  <= '0;
            bus.tx_flag  <= 1'b1;
            bus.idle     <= 1'b1;
`ifdef UART_TX_ARB_TAG_EN
            hold         <= '0;
`endif
        end else begin
            bus.ack <= '0;
            case (state)
                IDLE: begin
                    // The pick is registered one cycle, then confirmed against the live req.
                    if (pick_valid && bus.req[pick_id] && !bus.tx_busy) begin
                        last         <= pick_id;
                        bus.grant_id <= pick_id;
                        bus.ack      <= NREQ'(1) << pick_id;
                        bus.tx_flag  <= 1'b0;
                        bus.idle     <= 1'b0;
                        pick_valid   <= 1'b0;
`ifdef UART_TX_ARB_TAG_EN
                        hold         <= bus.req_data[int'(pick_id)*UART_DW +: UART_DW];
                        bus.tx_data  <= tag_byte(UART_DW'(pick_id));
                        state        <= TAG_LOAD;
`else
                        bus.tx_data  <= bus.req_data[int'(pick_id)*UART_DW +: UART_DW];
                        state        <= LOAD;
`endif
                    end else begin
                        pick_valid <= found && !bus.tx_busy;
                        pick_id    <= winner;
                        bus.idle   <= !(found && !bus.tx_busy);
                    end
                end
                LOAD: begin
                    if (bus.tx_busy) begin
                        bus.tx_flag <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (!bus.tx_busy) begin
                        bus.idle <= 1'b1;
                        state    <= IDLE;
                    end
                end
`ifdef UART_TX_ARB_TAG_EN
                TAG_LOAD: begin
                    if (bus.tx_busy) begin
                        bus.tx_flag <= 1'b1;
                        state       <= TAG_RUN;
                    end
                end
                TAG_RUN: begin
                    if (!bus.tx_busy) begin
                        bus.tx_data <= hold;
                        bus.tx_flag <= 1'b0;
                        state       <= LOAD;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter driving a send #(10) transmitter.
// Also exercises tag framing when UART_TX_ARB_TAG_EN is defined.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NREQ = 4;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  exp_ack;
        logic [1:0]  exp_grant;
        logic [7:0]  exp_byte;
    } vec_t;

    logic CLK = 1'b0;
    logic RESET_N;
    logic UART_TX;

    int checks  = 0;
    int errors  = 0;
    int ack_cnt = 0;

    vec_t       vecs [8];
    logic [3:0] a;
    logic [7:0] b;
    int         n;
    int         base;
    bit         line_low;
    bit         ack_seen;

    uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

    uart_tx_arbiter #(.NREQ(NREQ)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    send #(10) u_send (
        .CLK     (CLK),
        .RESET   (~RESET_N),
        .data    (bus.tx_data),
        .flag    (bus.tx_flag),
        .busy    (bus.tx_busy),
        .UART_TX (UART_TX)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (bus.ack != '0) ack_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] first_tx(input logic [1:0] g, input logic [7:0] d);
`ifdef UART_TX_ARB_TAG_EN
        return 8'hF0 | {6'b0, g};
`else
        return d;
`endif
    endfunction

    task automatic wait_ack(output logic [3:0] got, output int cyc);
        got = '0;
        cyc = 0;
        while (cyc < 600) begin
            @(negedge CLK);
            cyc++;
            if (bus.ack != '0) begin
                got = bus.ack;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL ack_timeout: no ack after %0d cycles, expected one", cyc);
    endtask

    task automatic wait_busy(input logic level);
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (bus.tx_busy === level) return;
        end
        checks++;
        errors++;
        $display("FAIL busy_timeout: tx_busy stuck, expected %0b", level);
    endtask

    task automatic recv_byte(input string name, input logic [7:0] exp);
        logic [7:0] r;
        bit         got_start;
        r = '0;
        got_start = 1'b0;
        for (int i = 0; i < 300 && !got_start; i++) begin
            @(negedge CLK);
            if (UART_TX === 1'b0) got_start = 1'b1;
        end
        if (!got_start) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no start bit seen, expected byte %0h", name, exp);
            return;
        end
        repeat (5) @(negedge CLK);
        check({name, "_start"}, {31'b0, UART_TX}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (10) @(negedge CLK);
            r[i] = UART_TX;
        end
        repeat (10) @(negedge CLK);
        check({name, "_stop"}, {31'b0, UART_TX}, 32'd1);
        check(name, {24'b0, r}, {24'b0, exp});
    endtask

    task automatic recv_frames(input string name, input logic [1:0] g, input logic [7:0] exp);
`ifdef UART_TX_ARB_TAG_EN
        recv_byte({name, "_tag"}, 8'hF0 | {6'b0, g});
`endif
        recv_byte(name, exp);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET_N      = 1'b0;
        bus.req      = '0;
        bus.req_data = '0;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // last starts at 3, so the single request first leaves last=2.
        vecs[0] = '{4'b1111, 32'hC3C2C1C0, 4'b1000, 2'd3, 8'hC3};
        vecs[1] = '{4'b1111, 32'h11223344, 4'b0001, 2'd0, 8'h44};
        vecs[2] = '{4'b0011, 32'h0F0E0D0C, 4'b0010, 2'd1, 8'h0D};
        vecs[3] = '{4'b0001, 32'h000000FF, 4'b0001, 2'd0, 8'hFF};
        vecs[4] = '{4'b1001, 32'h80000001, 4'b1000, 2'd3, 8'h80};
        vecs[5] = '{4'b0110, 32'h00AA5500, 4'b0010, 2'd1, 8'h55};
        vecs[6] = '{4'b1100, 32'h12345678, 4'b0100, 2'd2, 8'h34};
        vecs[7] = '{4'b0011, 32'hDEADBEEF, 4'b0001, 2'd0, 8'hEF};

        RESET_N      = 1'b0;
        bus.req      = '0;
        bus.req_data = '0;
        repeat (3) @(negedge CLK);
        check("rst_flag", {31'b0, bus.tx_flag}, 32'd1);
        check("rst_idle", {31'b0, bus.idle}, 32'd1);
        check("rst_ack", {28'b0, bus.ack}, 32'd0);
        check("rst_grant", {30'b0, bus.grant_id}, 32'd0);
        check("rst_tx_data", {24'b0, bus.tx_data}, 32'd0);
        RESET_N = 1'b1;

        line_low = 1'b0;
        ack_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (UART_TX !== 1'b1) line_low = 1'b1;
            if (bus.ack != '0 || bus.tx_flag !== 1'b1) ack_seen = 1'b1;
        end
        check("quiet_line_low", {31'b0, line_low}, 32'd0);
        check("quiet_activity", {31'b0, ack_seen}, 32'd0);

        // Single request: exact ack latency, one frame, idle afterwards.
        @(negedge CLK);
        bus.req      = 4'b0100;
        bus.req_data = 32'hA367A1A0;
        base         = ack_cnt;
        @(negedge CLK);
        check("single_ack_early", {28'b0, bus.ack}, 32'd0);
        @(negedge CLK);
        check("single_ack", {28'b0, bus.ack}, 32'h4);
        check("single_grant", {30'b0, bus.grant_id}, 32'd2);
        check("single_flag", {31'b0, bus.tx_flag}, 32'd0);
        check("single_tx_data", {24'b0, bus.tx_data}, {24'b0, first_tx(2'd2, 8'h67)});
        check("single_idle_busy", {31'b0, bus.idle}, 32'd0);
        bus.req = '0;
        recv_frames("single_rx", 2'd2, 8'h67);
        wait_busy(1'b0);
        repeat (2) @(negedge CLK);
        check("single_idle_after", {31'b0, bus.idle}, 32'd1);
        check("single_ack_count", ack_cnt - base, 32'd1);

        // Table of round-robin patterns continuing from last=2.
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            bus.req      = vecs[i].req;
            bus.req_data = vecs[i].data;
            wait_ack(a, n);
            check($sformatf("v%0d_ack", i), {28'b0, a}, {28'b0, vecs[i].exp_ack});
            check($sformatf("v%0d_grant", i), {30'b0, bus.grant_id}, {30'b0, vecs[i].exp_grant});
            check($sformatf("v%0d_tx_data", i), {24'b0, bus.tx_data},
                  {24'b0, first_tx(vecs[i].exp_grant, vecs[i].exp_byte)});
            bus.req = '0;
            recv_frames($sformatf("v%0d_rx", i), vecs[i].exp_grant, vecs[i].exp_byte);
            wait_busy(1'b0);
        end

        // All four requesting continuously from reset: 0,1,2,3 then wrap to 0.
        do_reset();
        @(negedge CLK);
        bus.req      = 4'b1111;
        bus.req_data = 32'hA3A2A1A0;
        for (int i = 0; i < 5; i++) begin
            wait_ack(a, n);
            if (i == 1) check("b2b_gap", n, 32'd3);
            check($sformatf("all_ack%0d", i), {28'b0, a}, 32'h1 << (i % 4));
            recv_frames($sformatf("all_rx%0d", i), 2'(i % 4), 8'hA0 + 8'(i % 4));
            wait_busy(1'b0);
        end
        bus.req = '0;

        // Requester 1 abandons its request while requester 0 is on the line.
        do_reset();
        @(negedge CLK);
        bus.req      = 4'b0011;
        bus.req_data = 32'hA3A2A1A0;
        wait_ack(a, n);
        check("drop_ack0", {28'b0, a}, 32'h1);
        bus.req = 4'b0010;
        wait_busy(1'b1);
        bus.req = 4'b1000;
        recv_frames("drop_rx0", 2'd0, 8'hA0);
        wait_ack(a, n);
        check("drop_skip_ack", {28'b0, a}, 32'h8);
        check("drop_skip_grant", {30'b0, bus.grant_id}, 32'd3);
        bus.req = '0;
        recv_frames("drop_rx3", 2'd3, 8'hA3);
        wait_busy(1'b0);

        // Reset pulse in the middle of a frame, with requests pending across it.
        @(negedge CLK);
        bus.req      = 4'b0010;
        bus.req_data = 32'hA3A2A1A0;
        wait_ack(a, n);
        check("mid_ack1", {28'b0, a}, 32'h2);
        wait_busy(1'b1);
        repeat (30) @(negedge CLK);
        bus.req = 4'b0101;
        RESET_N = 1'b0;
        #1;
        check("mid_rst_flag", {31'b0, bus.tx_flag}, 32'd1);
        check("mid_rst_ack", {28'b0, bus.ack}, 32'd0);
        check("mid_rst_idle", {31'b0, bus.idle}, 32'd1);
        check("mid_rst_grant", {30'b0, bus.grant_id}, 32'd0);
        check("mid_rst_line", {31'b0, UART_TX}, 32'd1);
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        wait_ack(a, n);
        check("mid_after_ack", {28'b0, a}, 32'h1);
        check("mid_after_grant", {30'b0, bus.grant_id}, 32'd0);
        bus.req = '0;
        recv_frames("mid_after_rx", 2'd0, 8'hA0);
        wait_busy(1'b0);

`ifdef UART_TX_ARB_TAG_EN
        // Tag framing: one grant, tag frame then data frame, one ack.
        do_reset();
        @(negedge CLK);
        bus.req      = 4'b1000;
        bus.req_data = 32'h55000000;
        base         = ack_cnt;
        wait_ack(a, n);
        check("tag_ack", {28'b0, a}, 32'h8);
        check("tag_tx_data", {24'b0, bus.tx_data}, 32'hF3);
        bus.req = '0;
        recv_byte("tag_rx_tag", 8'hF3);
        recv_byte("tag_rx_data", 8'h55);
        wait_busy(1'b0);
        repeat (5) @(negedge CLK);
        check("tag_ack_count", ack_cnt - base, 32'd1);
`endif

        repeat (5) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one `send` UART transmitter between `NREQ` byte producers. Each producer raises a request with a byte. The arbiter picks one, acknowledges it, and drives the `send` start handshake (`data`, active-low `flag`). It watches `busy` until the frame completes, then re-arbitrates. It sits between the CPU-side producers and the single `send` instance that drives `UART_TX`.

## Interface
- `NREQ`, 4, number of requesters, 2..16
- `IDW`, `$clog2(NREQ)`, width of the grant index (derived, do not override)
- `CLK`  in  1  system clock, all logic on rising edge
- `RESET_N`  in  1  asynchronous, active-low reset
- `req`  in  NREQ  per-requester request level
- `req_data`  in  NREQ*8  byte of requester i in bits [8i+7:8i]
- `ack`  out  NREQ  one-cycle pulse: byte of requester i captured
- `grant_id`  out  IDW  index of the requester currently being served
- `tx_data`  out  8  to `send.data`
- `tx_flag`  out  1  to `send.flag`; 0 = start request, 1 = idle
- `tx_busy`  in  1  from `send.busy`; 1 while a frame is on the line
- `idle`  out  1  1 when in IDLE and no transfer is pending

## Operation
- States are IDLE, LOAD and RUN.
  - With `UART_TX_ARB_TAG_EN`, two more states: TAG_LOAD and TAG_RUN.
- IDLE:
  - Arbitrates only when `tx_busy`=0 and `req`≠0.
  - Winner is the first set `req` bit searching upward from `last+1`, wrapping modulo NREQ.
  - On a win: `last`←winner, `grant_id`←winner, `tx_data`←`req_data[winner]`, `ack[winner]` pulses, go to LOAD.
- LOAD: `tx_flag`=0 and `tx_data` held stable. When `tx_busy` is sampled 1, set `tx_flag`←1 and go to RUN.
- RUN: `tx_flag`=1. When `tx_busy` is sampled 0, go to IDLE.
- Requester rules:
  - Hold `req` and `req_data` stable until `ack`.
  - The cycle after `ack`, the requester may drop `req` or present its next byte.
  - A requester that drops `req` before being served is skipped; no byte is sent for it.
- `req` changing while in LOAD or RUN has no effect until the next IDLE.
- At most one `ack` bit is high in any cycle.

## Timing
- Reset values:
  - `tx_flag`=1, `tx_data`=0, `ack`=0, `grant_id`=0, `idle`=1.
  - State IDLE, `last`=NREQ-1, so requester 0 has first priority.
- Async reset mid-frame: the arbiter returns to IDLE immediately and the in-flight byte is abandoned. `send` shares the reset (inverted at top level), so the line returns to idle.
- Cycle counts:
  - `req` high in IDLE at edge k → `ack`, `tx_flag`=0 and valid `tx_data` visible after edge k+1.
  - `tx_busy` rise sampled at edge m → `tx_flag`=1 after edge m.
  - `tx_busy` fall sampled at edge n → IDLE after n; the next `tx_flag` low comes after n+2.
- Back-to-back frames therefore have a minimum gap of 2 cycles between `busy` fall and the next start.
- Simultaneous requests: strict round-robin. With all NREQ requesting continuously, service order is `last+1, last+2, …`, and each requester gets one byte per NREQ frames.

## Configuration
- `UART_TX_ARB_TAG_EN` defined:
  - Each grant sends two frames: first a tag byte `TAG_BASE | grant_id` (`TAG_BASE`=8'hF0), then the data byte.
  - Path: IDLE→TAG_LOAD→TAG_RUN→LOAD→RUN→IDLE. `ack` still pulses once, at the IDLE→TAG_LOAD edge.
  - The data byte is captured at grant and held internally during the tag frame.
- Undefined: single data frame per grant. TAG states and the data holding register are not compiled.

## Structure
- Shared package `uart_pkg`:
  - State enum `arb_state_t`.
  - `TAG_BASE`.
  - Byte width constant `UART_DW`=8.
- One sub-module, `rr_pick`: combinational round-robin selector. Inputs `req`, `last`; outputs `winner` and `found`.
- The FSM and registers live in `uart_tx_arbiter`.
- Bench instantiates `send #(10)` with `CLK`, `RESET` = `~RESET_N`, `data`=`tx_data`, `flag`=`tx_flag`, `busy`=`tx_busy`.

## Test plan
- Reset held, then released with `req`=0:
  - `tx_flag`=1, `idle`=1, `ack`=0, `UART_TX` idle-high for 100 cycles.
- Single request `req`=4'b0100, `req_data[2]`=8'h67:
  - `ack`=4'b0100 for one cycle; `grant_id`=2.
  - One frame on `UART_TX` carrying 0x67.
  - `idle`=1 two cycles after `busy` falls.
- All four requesting (bytes 0xA0..0xA3) from reset:
  - Frames sent in order 0xA0, 0xA1, 0xA2, 0xA3.
  - Requester 0 re-requesting then yields 0xA0 after 0xA3 (wrap).
- Requester 1 drops `req` while requester 0 is in RUN:
  - Requester 1 is never acked; the next grant goes to the next active requester.
- `RESET_N` pulsed low mid-frame:
  - `tx_flag`=1 and `ack`=0 immediately.
  - After release, a pending request is served from requester 0.
- With `UART_TX_ARB_TAG_EN`, `req`=4'b1000, byte 0x55:
  - Frames 0xF3 then 0x55; exactly one `ack` pulse.
